// File: rtl/serial_frame_source.sv
// serial_frame_source: parallel-to-serial front end for the pattern detector.
// Takes WIDTH-bit words on a valid/ready handshake and shifts them out MSB
// first, one bit per clk, with an optional GAP-cycle idle gap after each frame.
// Optional build macro SERIAL_FRAME_PARITY_EN appends one even-parity bit to
// each frame. word_done and the GAP==0 reload window then move to that bit.
//
// Handshake: a word is taken at a posedge where in_valid && in_ready. in_ready
// depends only on registered state. in_data and in_valid are ignored while
// in_ready is low.
module serial_frame_source #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid,
    output logic             word_done,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

`ifdef SERIAL_FRAME_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);
    localparam bit         NO_GAP   = (GAP == 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             word_done_q, word_done_d;
`ifdef SERIAL_FRAME_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             last_bit;
    logic             accept;

    // Ready window: always in IDLE, and on the last frame cycle when there is no gap.
    always_comb begin
        last_bit = (state_q == S_SHIFT) && (bit_cnt_q == LAST_IDX);
        in_ready = (state_q == S_IDLE) || (NO_GAP && last_bit);
        accept   = in_valid && in_ready;
    end

    // Next-state logic: outputs default to the idle level (data=0, no valid).
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        data_d       = 1'b0;
        data_valid_d = 1'b0;
        word_done_d  = 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            S_SHIFT: begin
                if (bit_cnt_q != LAST_IDX) begin
                    bit_cnt_d    = bit_cnt_q + 6'd1;
                    data_valid_d = 1'b1;
                    word_done_d  = ((bit_cnt_q + 6'd1) == LAST_IDX);
                    shreg_d      = shreg_q << 1;
`ifdef SERIAL_FRAME_PARITY_EN
                    data_d = (bit_cnt_q == 6'(WIDTH - 1)) ? parity_q : shreg_q[WIDTH-1];
`else
                    data_d = shreg_q[WIDTH-1];
`endif
                end else if (NO_GAP) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = 4'(GAP);
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= 4'd1) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = 4'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A taken word always (re)starts a frame; the MSB goes out next cycle.
        if (accept) begin
            state_d      = S_SHIFT;
            shreg_d      = {in_data[WIDTH-2:0], 1'b0};
            bit_cnt_d    = 6'd0;
            data_d       = in_data[WIDTH-1];
            data_valid_d = 1'b1;
            word_done_d  = 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
            parity_d     = ^in_data;
`endif
        end
    end

    // State and output registers; reset drops any word offered in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            data_q       <= 1'b0;
            data_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            word_done_q  <= word_done_d;
`ifdef SERIAL_FRAME_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Registered outputs and state visibility.
    always_comb begin
        data       = data_q;
        data_valid = data_valid_q;
        word_done  = word_done_q;
        busy       = (state_q != S_IDLE);
        dbg_state  = state_q;
    end

endmodule

// File: doc/serial_frame_source.md
Name: serial_frame_source

Overview:
- Parallel-to-serial front end that produces the single-bit `data` stream consumed by the downstream FSM pattern detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB first, one bit per clk.
- Inserts an optional idle gap between words, so test and system logic can drive the detector with framed bit patterns.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- GAP, 0, idle cycles inserted after each word's last bit; legal range 0..15.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset, sampled on the posedge of clk.
- in_data  input  WIDTH  parallel word; sampled only on an accepted handshake.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  block can accept a word this cycle; combinational from registered state.
- data  output  1  serial bit to the detector; registered.
- data_valid  output  1  `data` carries a payload bit; registered.
- word_done  output  1  one-cycle pulse coincident with the final bit of a frame; registered.
- busy  output  1  high when state is not IDLE.

Behaviour:
- States: IDLE, SHIFT, GAP. Internal state is a WIDTH-bit shift register, bit counter bit_cnt, and gap counter gap_cnt.
- Reset, when rst=1 at posedge:
  - state=IDLE, data=0, data_valid=0, word_done=0, counters=0.
  - in_ready=1 from the first cycle after reset.
  - Reset overrides any handshake in the same cycle; that word is dropped.
- Accept condition: in_valid && in_ready at a posedge.
- IDLE:
  - in_ready=1, data=0, data_valid=0.
  - On accept: load shift register, bit_cnt=0, go to SHIFT.
  - First bit (in_data[WIDTH-1]) appears on data, with data_valid=1, in the cycle after accept. Latency is 1 clk.
- SHIFT:
  - Each cycle presents the next bit, MSB to LSB, with data_valid=1; bit_cnt increments.
  - Last frame cycle (bit_cnt==WIDTH-1): word_done=1.
  - GAP>0: next state is GAP with gap_cnt=GAP. in_ready=0 throughout SHIFT.
  - GAP==0: in_ready=1 only on the last frame cycle.
    - Accept on that cycle: reload and stay in SHIFT, giving a seamless back-to-back stream with no data_valid bubble.
    - No accept: go to IDLE.
- GAP:
  - data=0, data_valid=0, in_ready=0.
  - gap_cnt decrements each cycle; go to IDLE when it reaches 1. The gap lasts exactly GAP cycles.
- in_data and in_valid changes while in_ready=0 have no effect.
- data is held at 0 whenever data_valid=0; the detector sees a stable 0 level between frames.
- rst asserted mid-frame aborts the frame: the next cycle has data_valid=0, word_done is not pulsed, and no partial bits remain.

Optional Feature:
- Macro: SERIAL_FRAME_PARITY_EN.
- Defined:
  - Frame length is WIDTH+1. After the LSB, one even-parity bit (XOR of all WIDTH bits of the word) is sent with data_valid=1.
  - word_done and the GAP==0 in_ready window move to the parity cycle.
- Undefined: frame is exactly WIDTH bits and no parity logic is synthesised.

Test Plan:
- Reset, then in_valid=0 for 20 cycles -> in_ready=1, data=0, data_valid=0, busy=0, word_done=0 throughout.
- WIDTH=8, GAP=0, accept 8'hB0 at cycle T:
  - data = 1,0,1,1,0,0,0,0 on cycles T+1..T+8, data_valid=1 on those cycles.
  - word_done=1 only at T+8; IDLE at T+9.
- GAP=0, in_valid held high with 8'hB0 then 8'h5A:
  - 16 consecutive data_valid=1 cycles, bits 10110000 01011010.
  - in_ready=1 only at T and T+8.
- GAP=2, two words offered back to back:
  - data_valid=0 and in_ready=0 on T+9 and T+10.
  - Second word accepted at T+11, first bit at T+12.
- rst=1 on the cycle presenting bit 3 of 8'hFF -> following cycle data=0, data_valid=0, in_ready=1, no word_done pulse.
- SERIAL_FRAME_PARITY_EN defined, accept 8'hB0 -> bits 10110000 then parity 1 at T+9; word_done at T+9 only.
